// File: rtl/parking_lot_if.sv
// Parking-lot gate/status bundle.
// master: drives entry/exit strobes and car class, observes responses and status.
// slave : the controller; consumes strobes, drives responses, occupancy, vacancy,
//         full/over flags and the time of day.
interface parking_lot_if #(
    parameter int unsigned CNT_W = 11
);
    logic             entry_req;
    logic             entry_uni;
    logic             exit_req;
    logic             exit_uni;
    logic             entry_grant;
    logic             entry_deny;
    logic             exit_ack;
    logic             exit_err;
    logic [CNT_W-1:0] uni_parked;
    logic [CNT_W-1:0] guest_parked;
    logic [CNT_W-1:0] uni_vacant;
    logic [CNT_W-1:0] guest_vacant;
    logic             uni_full;
    logic             guest_full;
    logic             uni_over;
    logic             guest_over;
    logic [4:0]       hour;
    logic [5:0]       minute;
    logic [5:0]       second;

    modport master (
        output entry_req, entry_uni, exit_req, exit_uni,
        input  entry_grant, entry_deny, exit_ack, exit_err,
        input  uni_parked, guest_parked, uni_vacant, guest_vacant,
        input  uni_full, guest_full, uni_over, guest_over,
        input  hour, minute, second
    );

    modport slave (
        input  entry_req, entry_uni, exit_req, exit_uni,
        output entry_grant, entry_deny, exit_ack, exit_err,
        output uni_parked, guest_parked, uni_vacant, guest_vacant,
        output uni_full, guest_full, uni_over, guest_over,
        output hour, minute, second
    );
endinterface

// File: rtl/parking_lot_ctrl.sv
// Two-class parking-lot controller with time-of-day clock and hour-driven
// guest/uni capacity split.
// Ports:
//   clk   - system clock, rising edge
//   rst_n - synchronous active-low reset
//   bus   - parking_lot_if.slave: entry/exit strobes in; registered one-cycle
//           grant/deny/ack/err out; occupancy, vacancy, full/over and time out.
module parking_lot_ctrl #(
    parameter int unsigned TOTAL_CAP  = 700,
    parameter int unsigned CNT_W      = 11,
    parameter int unsigned SEC_DIV    = 1,
    parameter int unsigned START_HOUR = 8,
    parameter int unsigned GUEST_BASE = 200,
    parameter int unsigned GUEST_STEP = 50,
    parameter int unsigned GUEST_OFF  = 500
) (
    input logic          clk,
    input logic          rst_n,
    parking_lot_if.slave bus
);

    localparam int unsigned PRE_W = (SEC_DIV > 1) ? $clog2(SEC_DIV) : 1;

    localparam logic [CNT_W-1:0] TOTAL_C = CNT_W'(TOTAL_CAP);
    localparam logic [CNT_W-1:0] G_BASE  = CNT_W'(GUEST_BASE);
    localparam logic [CNT_W-1:0] G_H13   = CNT_W'(GUEST_BASE + GUEST_STEP);
    localparam logic [CNT_W-1:0] G_H14   = CNT_W'(GUEST_BASE + 2 * GUEST_STEP);
    localparam logic [CNT_W-1:0] G_H15   = CNT_W'(GUEST_BASE + 3 * GUEST_STEP);
    localparam logic [CNT_W-1:0] G_OFF   = CNT_W'(GUEST_OFF);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [PRE_W-1:0] presc_q, presc_d;
    logic [5:0]       sec_q, sec_d;
    logic [5:0]       min_q, min_d;
    logic [4:0]       hour_q, hour_d;

    logic [CNT_W-1:0] uni_q, uni_d;
    logic [CNT_W-1:0] guest_q, guest_d;
    logic             grant_q, deny_q, ack_q, err_q;

    logic [CNT_W-1:0] guest_cap_c, uni_cap_c;
    logic [CNT_W-1:0] ex_cnt_c, en_cnt_c, en_cap_c;
    logic             ex_ok_c, en_ok_c;

    // Prescaler and HH:MM:SS ripple carry
    always_comb begin
        presc_d = presc_q + PRE_W'(1);
        sec_d   = sec_q;
        min_d   = min_q;
        hour_d  = hour_q;
        if (presc_q == PRE_W'(SEC_DIV - 1)) begin
            presc_d = '0;
            if (sec_q == 6'd59) begin
                sec_d = '0;
                if (min_q == 6'd59) begin
                    min_d  = '0;
                    hour_d = (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end
    end

    // Capacity schedule from the current (pre-edge) hour
    always_comb begin
        guest_cap_c = G_OFF;
        if (hour_q >= 5'd8 && hour_q <= 5'd12) guest_cap_c = G_BASE;
        else if (hour_q == 5'd13)              guest_cap_c = G_H13;
        else if (hour_q == 5'd14)              guest_cap_c = G_H14;
        else if (hour_q == 5'd15)              guest_cap_c = G_H15;
        uni_cap_c = TOTAL_C - guest_cap_c;
    end

    // Request arbitration: exit first, then entry against the post-exit count
    always_comb begin
        ex_cnt_c = bus.exit_uni  ? uni_q     : guest_q;
        en_cnt_c = bus.entry_uni ? uni_q     : guest_q;
        en_cap_c = bus.entry_uni ? uni_cap_c : guest_cap_c;
        ex_ok_c  = bus.exit_req && (ex_cnt_c != '0);
        // A same-class exit frees its space for this cycle's entry; an
        // overbooked class still sees count >= cap and keeps denying.
        if (ex_ok_c && (bus.exit_uni == bus.entry_uni)) en_cnt_c = en_cnt_c - ONE;
        en_ok_c  = bus.entry_req && (en_cnt_c < en_cap_c);

        uni_d   = uni_q;
        guest_d = guest_q;
        if (ex_ok_c) begin
            if (bus.exit_uni) uni_d   = uni_d - ONE;
            else              guest_d = guest_d - ONE;
        end
        if (en_ok_c) begin
            if (bus.entry_uni) uni_d   = uni_d + ONE;
            else               guest_d = guest_d + ONE;
        end
    end

    // State registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q <= '0;
            sec_q   <= '0;
            min_q   <= '0;
            hour_q  <= 5'(START_HOUR);
            uni_q   <= '0;
            guest_q <= '0;
            grant_q <= 1'b0;
            deny_q  <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            presc_q <= presc_d;
            sec_q   <= sec_d;
            min_q   <= min_d;
            hour_q  <= hour_d;
            uni_q   <= uni_d;
            guest_q <= guest_d;
            grant_q <= en_ok_c;
            deny_q  <= bus.entry_req && !en_ok_c;
            ack_q   <= ex_ok_c;
            err_q   <= bus.exit_req && !ex_ok_c;
        end
    end

    // Status derived from registered counts and hour; vacancy floors at 0
    assign bus.entry_grant  = grant_q;
    assign bus.entry_deny   = deny_q;
    assign bus.exit_ack     = ack_q;
    assign bus.exit_err     = err_q;
    assign bus.uni_parked   = uni_q;
    assign bus.guest_parked = guest_q;
    assign bus.uni_over     = uni_q   > uni_cap_c;
    assign bus.guest_over   = guest_q > guest_cap_c;
    assign bus.uni_vacant   = (uni_q   > uni_cap_c)   ? '0 : uni_cap_c   - uni_q;
    assign bus.guest_vacant = (guest_q > guest_cap_c) ? '0 : guest_cap_c - guest_q;
    assign bus.uni_full     = (bus.uni_vacant   == '0);
    assign bus.guest_full   = (bus.guest_vacant == '0);
    assign bus.hour         = hour_q;
    assign bus.minute       = min_q;
    assign bus.second       = sec_q;

endmodule
